// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: programmable sample-tick generator, idle-line arming FSM,
// and a first-word-fall-through byte FIFO with valid/ready read port and sticky overrun.
module uart_rx_ctrl #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IDLE_TICKS = 160
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic                          rx,
  output logic                          baud_rate_sample_clk,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_data,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          armed
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 rx_done_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           mem [FIFO_DEPTH];

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 tick;
  logic                 full;
  logic                 pop;
  logic                 capture;
  logic                 wr_en;
  logic                 drop;

  assign div_eff = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  assign tick    = (state_q != ST_DISABLED) && (cnt_q == (shadow_q - DIV_WIDTH'(1)));

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign capture = rx_done & ~rx_done_q & (state_q == ST_RUN);
  assign wr_en   = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Arming FSM: idle counter only advances on ticks that see a high line.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    unique case (state_q)
      ST_DISABLED: begin
        if (enable) begin
          state_d = ST_ARMING;
          idle_d  = '0;
        end
      end
      ST_ARMING: begin
        if (!enable) begin
          state_d = ST_DISABLED;
        end else if (tick) begin
          if (rx_s_q) begin
            if (idle_q == IDLE_W'(IDLE_TICKS - 1)) state_d = ST_RUN;
            idle_d = idle_q + IDLE_W'(1);
          end else begin
            idle_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  // Tick counter and divisor shadow; a new divisor is picked up only at a period boundary.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (state_q == ST_DISABLED) begin
      cnt_d    = '0;
      shadow_d = div_eff;
    end else if (tick) begin
      cnt_d    = '0;
      shadow_d = div_eff;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // FIFO bookkeeping and sticky overrun (set beats clear).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_DISABLED;
      cnt_q     <= '0;
      shadow_q  <= DIV_WIDTH'(1);
      idle_q    <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_done_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      idle_q    <= idle_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_done_q <= rx_done;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage has no reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rx_data;
  end

  assign baud_rate_sample_clk = tick;
  assign out_data             = mem[rd_ptr_q];
  assign out_valid            = (count_q != '0);
  assign fifo_count           = count_q;
  assign overrun              = overrun_q;
  assign armed                = (state_q == ST_RUN);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO behaviour from a vector table, tick/arming/reset
// timing from hand-written sequences.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] divisor;
  logic        rx;
  logic        tick;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        overrun;
  logic        overrun_clr;
  logic        armed;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .divisor              (divisor),
    .rx                   (rx),
    .baud_rate_sample_clk (tick),
    .rx_done              (rx_done),
    .rx_data              (rx_data),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .fifo_count           (fifo_count),
    .overrun              (overrun),
    .overrun_clr          (overrun_clr),
    .armed                (armed)
  );

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_cnt;
    logic       exp_ov;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic d, input logic [7:0] dat, input logic r, input logic c,
                     input logic v, input logic [7:0] ed, input logic [3:0] ec, input logic eo);
    vec_t t;
    t.done = d; t.data = dat; t.rdy = r; t.clr = c;
    t.exp_valid = v; t.exp_data = ed; t.exp_cnt = ec; t.exp_ov = eo;
    tbl.push_back(t);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = d;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  initial begin
    int k, ticks, after, phase, lowk;
    int tpos[$];

    reset = 1'b0; enable = 1'b0; divisor = 16'd4; rx = 1'b1;
    rx_done = 1'b0; rx_data = 8'h00; out_ready = 1'b0; overrun_clr = 1'b0;

    // FIFO vector table: inputs before an edge, expected registered outputs after it.
    add(1, 8'h55, 0, 0, 1, 8'h55, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h55, 1, 0);
    add(1, 8'hA3, 0, 0, 1, 8'h55, 2, 0);
    add(0, 8'h00, 0, 0, 1, 8'h55, 2, 0);
    add(1, 8'h0F, 0, 0, 1, 8'h55, 3, 0);
    add(0, 8'h00, 1, 0, 1, 8'hA3, 2, 0);
    add(0, 8'h00, 1, 0, 1, 8'h0F, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    add(1, 8'h77, 0, 0, 1, 8'h77, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 8'h88, 0, 0, 1, 8'h77, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h77, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      add(1, 8'(i), 0, 0, 1, 8'h77, 4'(1 + i), 0);
      add(0, 8'h00, 0, 0, 1, 8'h77, 4'(1 + i), 0);
    end
    add(1, 8'hEE, 0, 0, 1, 8'h77, 8, 1);
    add(0, 8'h00, 0, 0, 1, 8'h77, 8, 1);
    add(0, 8'h00, 0, 1, 1, 8'h77, 8, 0);
    add(1, 8'h99, 1, 0, 1, 8'h01, 8, 0);
    add(0, 8'h00, 0, 0, 1, 8'h01, 8, 0);
    add(1, 8'hEE, 0, 1, 1, 8'h01, 8, 1);
    add(0, 8'h00, 0, 0, 1, 8'h01, 8, 1);
    add(0, 8'h00, 0, 1, 1, 8'h01, 8, 0);
    for (int i = 2; i <= 7; i++) add(0, 8'h00, 1, 0, 1, 8'(i), 4'(9 - i), 0);
    add(0, 8'h00, 1, 0, 1, 8'h99, 1, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_armed", 32'(armed), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) enable = 1'b1;

    // First arming: tick phase, 160 ticks, no capture while arming.
    k = 0; ticks = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (armed) break;
      if (k < 12) chk("tick_phase", 32'(tick), 32'(k % 4 == 3));
      if (tick) ticks++;
      rx_done = (k == 5);
      rx_data = 8'h5A;
      k++;
    end
    chk("arm_ticks", 32'(ticks), 160);
    chk("arm_cycles", 32'(k), 640);
    chk("arming_no_capture", 32'(fifo_count), 0);

    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_armed", 32'(armed), 0);
    ticks = 0;
    repeat (6) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("disabled_no_ticks", 32'(ticks), 0);

    // Second arming with a low glitch after the 100th tick.
    @(negedge clk) enable = 1'b1;
    k = 0; ticks = 0; after = 0; phase = 0; lowk = 0;
    while (k < 3000) begin
      @(negedge clk);
      if (armed) break;
      if (tick) ticks++;
      if (phase == 2 && tick) after++;
      if (phase == 0 && tick && ticks == 100) begin
        rx = 1'b0; phase = 1; lowk = k;
      end else if (phase == 1 && k == lowk + 8) begin
        chk("glitch_end_on_tick", 32'(tick), 1);
        rx = 1'b1; phase = 2;
      end
      k++;
    end
    chk("rearm_armed", 32'(armed), 1);
    chk("rearm_ticks_after_glitch", 32'(after), 160);

    foreach (tbl[i]) begin
      @(negedge clk);
      rx_done = tbl[i].done; rx_data = tbl[i].data;
      out_ready = tbl[i].rdy; overrun_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
    end
    @(negedge clk);
    rx_done = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;

    // Divisor change mid-period: current period keeps 4, later ones use 10.
    k = 0;
    while (k < 20 && !tick) begin
      @(negedge clk);
      k++;
    end
    chk("div_sync_tick", 32'(tick), 1);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 2) divisor = 16'd10;
      if (tick) tpos.push_back(j);
    end
    chk("div_tick_count", 32'(tpos.size()), 3);
    if (tpos.size() == 3) begin
      chk("div_tick0", 32'(tpos[0]), 4);
      chk("div_tick1", 32'(tpos[1]), 14);
      chk("div_tick2", 32'(tpos[2]), 24);
    end

    divisor = 16'd0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (k < 30 && !tick);
    ticks = 0;
    repeat (5) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("div0_every_cycle", 32'(ticks), 5);

    // Disable with two bytes queued: bytes survive and remain readable.
    push_byte(8'h3C);
    push_byte(8'hC3);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_armed", 32'(armed), 0);
    ticks = 0;
    repeat (8) begin
      @(negedge clk);
      if (tick) ticks++;
    end
    chk("dis_no_ticks", 32'(ticks), 0);
    chk("dis_count", 32'(fifo_count), 2);
    chk("dis_head", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("dis_read2", 32'(out_data), 32'hC3);
    chk("dis_count1", 32'(fifo_count), 1);
    @(posedge clk); #1;
    chk("dis_empty", 32'(out_valid), 0);
    @(negedge clk) out_ready = 1'b0;

    // Async reset in the middle of a running period with a byte queued.
    enable = 1'b1;
    k = 0;
    while (k < 1000 && !armed) begin
      @(negedge clk);
      k++;
    end
    chk("arm3", 32'(armed), 1);
    push_byte(8'h42);
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 1);
    chk("pre_rst_tick", 32'(tick), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tick", 32'(tick), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_count", 32'(fifo_count), 0);
    chk("async_rst_armed", 32'(armed), 0);
    chk("async_rst_overrun", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
